dmem_portb_arbiter: RTL and testbench

- Parametrised round-robin arbiter that multiplexes NUM_REQ masters onto the shared wide port B of the DMEM dual-port RAM.
- Masters include the accelerator BRAM reader, the CCD frame writer and future DMA channels.
- Replaces the fixed priority mux (accelerator read over CCD write) with fair, burst-capable, latency-tracked access.
- Routes read data back to the requester that issued each read, even after ownership has moved on.

---
 rtl/dmem_portb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_portb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_portb_arbiter.sv
// Round-robin arbiter sharing DMEM port B between NUM_REQ masters, with burst
// ownership, forced release after MAX_BURST beats and tagged read-data return.
module dmem_portb_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int AW        = 7,
  parameter int DW        = 256,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    wr,
  input  logic [NUM_REQ-1:0]    last,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic [AW-1:0]         ram_addr,
  output logic [DW-1:0]         ram_data,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DW-1:0]         ram_q
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("dmem_portb_arbiter: NUM_REQ must be at least 2");
  end
  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("dmem_portb_arbiter: RD_LAT must be at least 1");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("dmem_portb_arbiter: MAX_BURST must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   prio_ptr_q, prio_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [OW-1:0]   pipe_tag_q [RD_LAT];
  logic [OW-1:0]   pipe_tag_d [RD_LAT];

  logic            arb_hit;
  logic [OW-1:0]   arb_idx;
  logic [OW-1:0]   next_ptr;
  logic            own_req, own_wr, own_last, beat;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;

  // Round-robin pick: first requester at or above prio_ptr, wrapping.
  always_comb begin
    int idx;
    arb_hit = 1'b0;
    arb_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(prio_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_hit && req[idx]) begin
        arb_hit = 1'b1;
        arb_idx = OW'(idx);
      end
    end
  end

  assign own_req   = req[owner_q];
  assign own_wr    = wr[owner_q];
  assign own_last  = last[owner_q];
  assign own_addr  = addr[int'(owner_q)*AW +: AW];
  assign own_wdata = wdata[int'(owner_q)*DW +: DW];
  assign next_ptr  = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    owner_d    = owner_q;
    prio_ptr_d = prio_ptr_q;
    beat_cnt_d = beat_cnt_q;
    gnt        = '0;
    beat       = 1'b0;
    ram_rden   = 1'b0;
    ram_wren   = 1'b0;
    ram_addr   = '0;
    ram_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          owner_d    = arb_idx;
          beat_cnt_d = '0;
          state_d    = OWN;
        end
      end

      OWN: begin
        ram_addr     = own_addr;
        ram_data     = own_wdata;
        gnt[owner_q] = own_req;
        beat         = own_req;
        if (beat) begin
          ram_wren = own_wr;
          ram_rden = ~own_wr;
        end
        // Release on a final beat, a burst-limit beat, or a dropped request.
        if (!own_req || own_last || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
          state_d    = IDLE;
          prio_ptr_d = next_ptr;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Read-return pipeline tracks the issuing requester independent of ownership.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_vld_d[0] = ram_rden;
    pipe_tag_d[0] = owner_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_comb begin
    rvalid = '0;
    if (pipe_vld_q[RD_LAT-1]) rvalid[pipe_tag_q[RD_LAT-1]] = 1'b1;
    rdata = ram_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      prio_ptr_q <= '0;
      beat_cnt_q <= '0;
      pipe_vld_q <= '0;
      // NOTE: the tag array is tiny and must not hold stale tags after reset,
      // so it is reset explicitly rather than left as an unreset memory.
      for (int i = 0; i < RD_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed before the edge, independent of statement order.
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_ptr_q <= prio_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Directed bench for dmem_portb_arbiter: queued requester models, a 2-cycle
// RAM model, and hand-computed per-cycle expectations for each scenario.
module tb_dmem_portb_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int AW        = 7;
  localparam int DW        = 256;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 16;

  typedef logic [DW-1:0] w_t;
  typedef struct packed {
    logic          wr;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req, wr, last, gnt, rvalid;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [DW-1:0]         rdata, ram_data, ram_q;
  logic [AW-1:0]         ram_addr;
  logic                  ram_rden, ram_wren;

  dmem_portb_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .last(last), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic w_t row_of(input logic [AW-1:0] a);
    return {8{8'h5A, 17'd0, a}};
  endfunction

  function automatic w_t wpat(input int i);
    return {8{8'hD0, 24'(i)}};
  endfunction

  // RAM model: registered read plus one output register, i.e. 2-cycle latency.
  w_t   mem [128];
  w_t   q_s1, q_s2;
  logic init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= row_of(7'(i));
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    if (ram_rden) q_s1 <= mem[ram_addr];
    q_s2 <= q_s1;
  end
  assign ram_q = q_s2;

  int n_vec = 0;
  int n_bad = 0;
  int cyc;
  beat_t q0[$];
  beat_t q1[$];
  logic [1:0]    gnt_l  [64];
  logic [1:0]    rv_l   [64];
  w_t            rd_l   [64];
  logic          rden_l [64];
  logic          wren_l [64];
  logic [AW-1:0] addr_l [64];
  w_t            data_l [64];
  logic [1:0]    exp_p2 [7];
  logic [1:0]    exp_p2b[5];

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_drive();
    req = '0; wr = '0; last = '0; addr = '0; wdata = '0;
    if (q0.size() != 0) begin
      req[0] = 1'b1; wr[0] = q0[0].wr; last[0] = q0[0].last;
      addr[AW-1:0] = q0[0].addr; wdata[DW-1:0] = q0[0].data;
    end
    if (q1.size() != 0) begin
      req[1] = 1'b1; wr[1] = q1[0].wr; last[1] = q1[0].last;
      addr[2*AW-1:AW] = q1[0].addr; wdata[2*DW-1:DW] = q1[0].data;
    end
  endtask

  task automatic push(input int r, input logic w, input logic l,
                      input logic [AW-1:0] a, input w_t d);
    beat_t b;
    b.wr = w; b.last = l; b.addr = a; b.data = d;
    if (r == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  // Sample the current cycle at negedge, then advance past the next posedge.
  task automatic step();
    logic [1:0] g;
    @(negedge clk);
    if (cyc < 64) begin
      gnt_l[cyc] = gnt;   rv_l[cyc]   = rvalid;   rd_l[cyc]   = rdata;
      rden_l[cyc] = ram_rden; wren_l[cyc] = ram_wren;
      addr_l[cyc] = ram_addr; data_l[cyc] = ram_data;
    end
    check("rd_wr_excl", w_t'(ram_rden & ram_wren), w_t'(0));
    g = gnt;
    @(posedge clk);
    #1;
    if (g[0] && q0.size() != 0) q0.delete(0);
    if (g[1] && q1.size() != 0) q1.delete(0);
    apply_drive();
    cyc++;
  endtask

  task automatic begin_phase();
    for (int i = 0; i < 64; i++) begin
      gnt_l[i] = 'x; rv_l[i] = 'x; rd_l[i] = 'x; rden_l[i] = 'x;
      wren_l[i] = 'x; addr_l[i] = 'x; data_l[i] = 'x;
    end
    cyc = 0;
    apply_drive();
  endtask

  initial begin
    exp_p2  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    exp_p2b = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    cyc = 0;
    reset = 1'b1;
    init_mem = 1'b1;
    req = '0; wr = '0; last = '0; addr = '0; wdata = '0;
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    // Reset state with live requests on the inputs.
    req = 2'b11; addr = {7'h33, 7'h22}; wdata = {512{1'b1}};
    @(negedge clk);
    check("rst_gnt",      w_t'(gnt),      w_t'(0));
    check("rst_rvalid",   w_t'(rvalid),   w_t'(0));
    check("rst_rden",     w_t'(ram_rden), w_t'(0));
    check("rst_wren",     w_t'(ram_wren), w_t'(0));
    check("rst_ram_addr", w_t'(ram_addr), w_t'(0));
    check("rst_ram_data", ram_data,       w_t'(0));
    @(posedge clk);
    #1;
    apply_drive();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Phase 1: single requester 1 reading 0x10..0x13.
    for (int i = 0; i < 4; i++) push(1, 1'b0, (i == 3), 7'(16 + i), w_t'(0));
    begin_phase();
    repeat (9) step();
    for (int c = 0; c <= 6; c++)
      check($sformatf("p1_gnt_c%0d", c), w_t'(gnt_l[c]),
            w_t'((c >= 1 && c <= 4) ? 2'b10 : 2'b00));
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("p1_rden_c%0d", c), w_t'(rden_l[c]), w_t'(1));
      check($sformatf("p1_addr_c%0d", c), w_t'(addr_l[c]), w_t'(16 + c - 1));
    end
    for (int c = 2; c <= 7; c++)
      check($sformatf("p1_rvalid_c%0d", c), w_t'(rv_l[c]),
            w_t'((c >= 3 && c <= 6) ? 2'b10 : 2'b00));
    for (int c = 3; c <= 6; c++)
      check($sformatf("p1_rdata_c%0d", c), rd_l[c], row_of(7'(16 + c - 3)));
    check("p1_drained", w_t'(q1.size()), w_t'(0));

    // Phase 2: simultaneous contention, req0 wins, one IDLE gap, then req1.
    push(0, 1'b1, 1'b0, 7'h40, wpat(64));
    push(0, 1'b1, 1'b1, 7'h41, wpat(65));
    push(1, 1'b1, 1'b0, 7'h42, wpat(66));
    push(1, 1'b1, 1'b1, 7'h43, wpat(67));
    begin_phase();
    repeat (8) step();
    for (int c = 0; c < 7; c++)
      check($sformatf("p2_gnt_c%0d", c), w_t'(gnt_l[c]), w_t'(exp_p2[c]));
    check("p2_wren_c4", w_t'(wren_l[4]), w_t'(1));
    check("p2_addr_c4", w_t'(addr_l[4]), w_t'(7'h42));
    check("p2_data_c4", data_l[4], wpat(66));

    // Phase 2b: second contention starts again from requester 0.
    push(0, 1'b1, 1'b1, 7'h44, wpat(68));
    push(1, 1'b1, 1'b1, 7'h45, wpat(69));
    begin_phase();
    repeat (6) step();
    for (int c = 0; c < 5; c++)
      check($sformatf("p2b_gnt_c%0d", c), w_t'(gnt_l[c]), w_t'(exp_p2b[c]));

    // Phase 3: 20-beat stream from req0 is cut at 16 beats, req1 slips in.
    for (int i = 0; i < 20; i++) push(0, 1'b1, 1'b0, 7'(8'h50 + i), wpat(i));
    for (int i = 0; i < 3; i++)  push(1, 1'b1, (i == 2), 7'(8'h70 + i), wpat(100 + i));
    begin_phase();
    repeat (29) step();
    for (int c = 0; c <= 27; c++) begin
      logic [1:0] e;
      if      (c >= 1  && c <= 16) e = 2'b01;
      else if (c >= 18 && c <= 20) e = 2'b10;
      else if (c >= 22 && c <= 25) e = 2'b01;
      else                         e = 2'b00;
      check($sformatf("p3_gnt_c%0d", c), w_t'(gnt_l[c]), w_t'(e));
    end
    check("p3_addr_c16", w_t'(addr_l[16]), w_t'(7'h5F));
    check("p3_wren_c16", w_t'(wren_l[16]), w_t'(1));
    check("p3_addr_c22", w_t'(addr_l[22]), w_t'(7'h60));
    check("p3_data_c22", data_l[22], wpat(16));
    check("p3_drained",  w_t'(q0.size() + q1.size()), w_t'(0));

    // Phase 4: req0 read in flight completes to req0 after req1 takes over.
    push(0, 1'b0, 1'b0, 7'h04, w_t'(0));
    push(0, 1'b0, 1'b1, 7'h05, w_t'(0));
    begin_phase();
    step();
    push(1, 1'b0, 1'b1, 7'h30, w_t'(0));
    apply_drive();
    repeat (8) step();
    check("p4_gnt_c1", w_t'(gnt_l[1]), w_t'(2'b01));
    check("p4_gnt_c2", w_t'(gnt_l[2]), w_t'(2'b01));
    check("p4_gnt_c3", w_t'(gnt_l[3]), w_t'(2'b00));
    check("p4_gnt_c4", w_t'(gnt_l[4]), w_t'(2'b10));
    check("p4_rvalid_c3", w_t'(rv_l[3]), w_t'(2'b01));
    check("p4_rdata_c3",  rd_l[3], row_of(7'h04));
    check("p4_rvalid_c4", w_t'(rv_l[4]), w_t'(2'b01));
    check("p4_rdata_c4",  rd_l[4], row_of(7'h05));
    check("p4_rvalid_c5", w_t'(rv_l[5]), w_t'(2'b00));
    check("p4_rvalid_c6", w_t'(rv_l[6]), w_t'(2'b10));
    check("p4_rdata_c6",  rd_l[6], row_of(7'h30));
    check("p4_rvalid_c7", w_t'(rv_l[7]), w_t'(2'b00));

    // Phase 5: CCD-role write of 0xAA..A, then accel-role read-back.
    push(1, 1'b1, 1'b1, 7'h20, {64{4'hA}});
    begin_phase();
    repeat (2) step();
    push(0, 1'b0, 1'b1, 7'h20, w_t'(0));
    apply_drive();
    repeat (5) step();
    check("p5_gnt_c1",    w_t'(gnt_l[1]), w_t'(2'b10));
    check("p5_wren_c1",   w_t'(wren_l[1]), w_t'(1));
    check("p5_gnt_c3",    w_t'(gnt_l[3]), w_t'(2'b01));
    check("p5_rvalid_c4", w_t'(rv_l[4]), w_t'(2'b00));
    check("p5_rvalid_c5", w_t'(rv_l[5]), w_t'(2'b01));
    check("p5_rdata_c5",  rd_l[5], {64{4'hA}});

    // Phase 6: reset with two reads from req0 in flight.
    for (int i = 0; i < 4; i++) push(0, 1'b0, (i == 3), 7'(8 + i), w_t'(0));
    begin_phase();
    repeat (3) step();
    check("p6_gnt_c1", w_t'(gnt_l[1]), w_t'(2'b01));
    check("p6_rden_c2", w_t'(rden_l[2]), w_t'(1));
    reset = 1'b1;
    #1;
    check("p6_rst_gnt",    w_t'(gnt),      w_t'(0));
    check("p6_rst_rden",   w_t'(ram_rden), w_t'(0));
    check("p6_rst_wren",   w_t'(ram_wren), w_t'(0));
    check("p6_rst_rvalid", w_t'(rvalid),   w_t'(0));
    q0.delete();
    apply_drive();
    step();
    check("p6_rst_rvalid_c3", w_t'(rv_l[3]), w_t'(0));
    reset = 1'b0;
    push(0, 1'b1, 1'b1, 7'h48, wpat(72));
    push(1, 1'b1, 1'b1, 7'h49, wpat(73));
    begin_phase();
    repeat (7) step();
    for (int c = 0; c <= 5; c++)
      check($sformatf("p6_post_rvalid_c%0d", c), w_t'(rv_l[c]), w_t'(0));
    check("p6_post_gnt_c1", w_t'(gnt_l[1]), w_t'(2'b01));
    check("p6_post_gnt_c3", w_t'(gnt_l[3]), w_t'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
